soc_sysid_arbiter: RTL and testbench
====================================

# soc_sysid_arbiter

Two-master read arbiter and sequencer for the system-ID slave (and any other read-only Avalon-MM register slave with a fixed read latency). It accepts Avalon-MM read requests from two masters, such as the two processor data masters, and grants them round-robin. It issues exactly one slave read per grant, captures the slave data after a fixed latency, and returns it to the granted master by dropping that master's waitrequest. It also flags a sticky protocol error if a master abandons a read that is still waiting.

## Interface

Parameters:
- ADDR_W, 1, slave/master address width in words
- DATA_W, 32, read data width
- READ_LATENCY, 0, slave read latency in cycles; legal range 0..3

Ports:
- clock, in, 1, sole clock; all state changes on its rising edge
- reset, in, 1, asynchronous, active-high
- m0_read, in, 1, master 0 read request; held until m0_waitrequest is low
- m0_address, in, ADDR_W, master 0 word address; stable while m0_read is high
- m0_readdata, out, DATA_W, master 0 read data; valid when m0_read=1 and m0_waitrequest=0
- m0_waitrequest, out, 1, master 0 stall
- m1_read / m1_address / m1_readdata / m1_waitrequest, as m0 for master 1
- s_read, out, 1, slave read strobe; exactly one cycle per transaction
- s_address, out, ADDR_W, slave address
- s_readdata, in, DATA_W, slave read data
- protocol_error, out, 1, sticky abandoned-read flag

## Operation

- FSM states and transitions:
  - IDLE: wait for a request; move to ISSUE when any mN_read is high.
  - ISSUE: drive the slave read for one cycle; move to WAIT when READ_LATENCY>0, otherwise to RESP.
  - WAIT: count down the slave latency; move to RESP when the countdown ends.
  - RESP: complete the transaction; always return to IDLE.
- IDLE behaviour:
  - When any mN_read is high, select a winner and latch its index and address. Move to ISSUE.
  - Arbitration: if only one master requests, that master wins.
  - If both request, the master not served last wins. The last-served pointer resets to 1, so master 0 wins the first contested arbitration.
  - The last-served pointer updates only on a completed RESP.
- ISSUE behaviour:
  - s_read=1 and s_address=latched address for exactly this cycle.
  - If READ_LATENCY=0, capture s_readdata into the data register on this edge and move to RESP.
  - Otherwise load the latency counter with READ_LATENCY-1 and move to WAIT.
- WAIT behaviour:
  - Decrement the counter each cycle.
  - When the counter is 0, capture s_readdata and move to RESP.
- RESP behaviour:
  - The winner sees waitrequest=0 and readdata=captured data for exactly one cycle.
  - Return to IDLE.
- Abandon:
  - If the winner's read is low during ISSUE, WAIT or RESP, skip completion. Do not lower waitrequest, set protocol_error, and return to IDLE after the slave access finishes.
  - The last-served pointer is not updated on an abandon.
- Output rules:
  - mN_waitrequest = 1 except for the winner in RESP.
  - mN_readdata of both masters carry the same data register; only the winner's copy is qualified by its waitrequest.
  - s_read is high only in ISSUE. s_address holds its last value outside ISSUE.
- Address change: a change of the latched master's address mid-transaction is ignored; the latched address is used.

## Timing

- Reset values (applied asynchronously on reset=1):
  - state=IDLE
  - m0_waitrequest=m1_waitrequest=1
  - m0_readdata=m1_readdata=0
  - s_read=0, s_address=0
  - protocol_error=0, last-served pointer=1
- Latency: read first seen high in IDLE at edge k → s_read high in cycle k+1 → waitrequest low in cycle k+2+READ_LATENCY.
- Throughput:
  - One transaction per 3+READ_LATENCY cycles.
  - A master holding read high right after its RESP is re-arbitrated in the following IDLE.
  - With both masters continuously requesting, grants strictly alternate 0,1,0,1.
- Losing master: its waitrequest stays 1 with no timeout, and it is served in the next IDLE.
- Simultaneous new request during RESP: not sampled until IDLE.
- Reset mid-transaction: immediate return to reset values. Any s_read in flight is dropped with no completion, and protocol_error is not set.

## Test plan

- Single read, READ_LATENCY=0, slave stub returning 0x0000_0000 @0 and 0x6239_F22B @1.
  - Stimulus: m0 reads addr 1.
  - Response: s_read one cycle later with s_address=1; m0_waitrequest low 2 cycles after the request with m0_readdata=0x6239_F22B; m1_waitrequest stays 1.
- Contention.
  - Stimulus: m0 and m1 assert read on the same edge and hold for 4 transactions.
  - Response: grants m0,m1,m0,m1; each master completes every 6 cycles; s_read pulses exactly 4 times.
- Latency sweep, READ_LATENCY=3.
  - Stimulus: m1 reads addr 0 while the stub drives data only 3 cycles after s_read.
  - Response: m1_waitrequest low exactly 5 cycles after the request with readdata=0; stale bus values before capture are never returned.
- Abandon.
  - Stimulus: m0 drops read in WAIT.
  - Response: no waitrequest-low cycle; protocol_error=1 and held until reset; a subsequent m1 read completes normally.
- Reset mid-operation.
  - Stimulus: assert reset during ISSUE.
  - Response: s_read=0 and all waitrequest=1 in the same cycle (asynchronous); protocol_error=0; after release, the next contested request goes to m0.

Source files
------------

// File: rtl/soc_sysid_arbiter.sv
// Two-master round-robin read arbiter/sequencer for a fixed-latency read-only
// Avalon-MM slave (e.g. system ID). One slave read per grant.
module soc_sysid_arbiter #(
  parameter int unsigned ADDR_W       = 1,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_read,
  input  logic [ADDR_W-1:0] m0_address,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,
  input  logic              m1_read,
  input  logic [ADDR_W-1:0] m1_address,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,
  output logic              s_read,
  output logic [ADDR_W-1:0] s_address,
  input  logic [DATA_W-1:0] s_readdata,
  output logic              protocol_error
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] CNT_INIT = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

  state_t            state;
  logic              winner;
  logic              last_served;
  logic              abandoned;
  logic [1:0]        count;
  logic [DATA_W-1:0] data_q;
  logic              winner_read;
  logic              pick;

  assign winner_read = winner ? m1_read : m0_read;
  // Both requesting: the master not served last wins; otherwise the sole requester.
  assign pick        = (m0_read && m1_read) ? ~last_served : m1_read;

  assign m0_readdata = data_q;
  assign m1_readdata = data_q;

  always_comb begin
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    if (state == RESP && !abandoned) begin
      if (!winner && m0_read) m0_waitrequest = 1'b0;
      if (winner && m1_read)  m1_waitrequest = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      winner         <= 1'b0;
      last_served    <= 1'b1;
      abandoned      <= 1'b0;
      count          <= '0;
      data_q         <= '0;
      s_read         <= 1'b0;
      s_address      <= '0;
      protocol_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_read || m1_read) begin
            winner    <= pick;
            s_address <= pick ? m1_address : m0_address;
            s_read    <= 1'b1;
            abandoned <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          s_read <= 1'b0;
          if (!winner_read) begin
            abandoned      <= 1'b1;
            protocol_error <= 1'b1;
          end
          if (READ_LATENCY == 0) begin
            data_q <= s_readdata;
            state  <= RESP;
          end else begin
            count <= CNT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!winner_read) begin
            abandoned      <= 1'b1;
            protocol_error <= 1'b1;
          end
          if (count == 2'd0) begin
            data_q <= s_readdata;
            state  <= RESP;
          end else begin
            count <= count - 2'd1;
          end
        end
        RESP: begin
          // An abandoned access still runs to RESP so the slave timing is uniform.
          if (!abandoned && winner_read) last_served <= winner;
          if (!winner_read) protocol_error <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_sysid_arbiter.sv
// Directed bench: cycle table on a READ_LATENCY=0 instance, hand sequences on a
// READ_LATENCY=3 instance (latency, abandon) and a mid-transaction reset.
module tb_soc_sysid_arbiter;

  localparam logic [31:0] K     = 32'h6239_F22B;
  localparam logic [31:0] STALE = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: READ_LATENCY=0, combinational stub.
  logic        a_m0r = 0, a_m1r = 0;
  logic [0:0]  a_m0a = '0, a_m1a = '0;
  logic [31:0] a_m0d, a_m1d, a_sd;
  logic        a_m0w, a_m1w, a_sr, a_pe;
  logic [0:0]  a_sa;

  // Instance B: READ_LATENCY=3, stub valid only 3 cycles after s_read.
  logic        b_m0r = 0, b_m1r = 0;
  logic [0:0]  b_m0a = '0, b_m1a = '0;
  logic [31:0] b_m0d, b_m1d, b_sd;
  logic        b_m0w, b_m1w, b_sr, b_pe;
  logic [0:0]  b_sa;
  logic [2:0]  b_pipe;
  logic [0:0]  b_lat;

  soc_sysid_arbiter #(.ADDR_W(1), .DATA_W(32), .READ_LATENCY(0)) dut0 (
    .clock(clk), .reset(rst),
    .m0_read(a_m0r), .m0_address(a_m0a), .m0_readdata(a_m0d), .m0_waitrequest(a_m0w),
    .m1_read(a_m1r), .m1_address(a_m1a), .m1_readdata(a_m1d), .m1_waitrequest(a_m1w),
    .s_read(a_sr), .s_address(a_sa), .s_readdata(a_sd), .protocol_error(a_pe));

  soc_sysid_arbiter #(.ADDR_W(1), .DATA_W(32), .READ_LATENCY(3)) dut3 (
    .clock(clk), .reset(rst),
    .m0_read(b_m0r), .m0_address(b_m0a), .m0_readdata(b_m0d), .m0_waitrequest(b_m0w),
    .m1_read(b_m1r), .m1_address(b_m1a), .m1_readdata(b_m1d), .m1_waitrequest(b_m1w),
    .s_read(b_sr), .s_address(b_sa), .s_readdata(b_sd), .protocol_error(b_pe));

  assign a_sd = (a_sa == 1'b1) ? K : 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      b_pipe <= '0;
      b_lat  <= '0;
    end else begin
      b_pipe <= {b_pipe[1:0], b_sr};
      if (b_sr) b_lat <= b_sa;
    end
  end
  assign b_sd = b_pipe[2] ? ((b_lat == 1'b1) ? K : 32'h0) : STALE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        m0r;
    logic [0:0]  m0a;
    logic        m1r;
    logic [0:0]  m1a;
    logic        ew0;
    logic        ew1;
    logic        esr;
    logic [0:0]  esa;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl [0:18];

  // READ_LATENCY=3 read by one master; waitrequest low exactly 5 cycles after request.
  task automatic rl3_read(input bit m, input logic [0:0] addr, input logic [31:0] exp);
    @(negedge clk);
    if (m) begin b_m1r = 1; b_m1a = addr; end else begin b_m0r = 1; b_m0a = addr; end
    #1;
    chk("rl3 c0 m0_wait", 32'(b_m0w), 32'd1);
    chk("rl3 c0 m1_wait", 32'(b_m1w), 32'd1);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk); #1;
      chk($sformatf("rl3 c%0d m%0d_wait", n, m), 32'(m ? b_m1w : b_m0w), (n == 5) ? 32'd0 : 32'd1);
      chk($sformatf("rl3 c%0d other_wait", n), 32'(m ? b_m0w : b_m1w), 32'd1);
      if (n == 1) begin
        chk("rl3 s_read", 32'(b_sr), 32'd1);
        chk("rl3 s_address", 32'(b_sa), 32'(addr));
      end
      if (n == 5) chk("rl3 readdata", m ? b_m1d : b_m0d, exp);
    end
    @(negedge clk);
    b_m0r = 0; b_m1r = 0;
    #1;
    chk("rl3 c6 wait", 32'(m ? b_m1w : b_m0w), 32'd1);
  endtask

  initial begin
    int pulses;
    //          rst m0r m0a m1r m1a ew0 ew1 esr esa ed
    tbl[0]  = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 32'h0};
    tbl[1]  = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 32'h0};
    tbl[2]  = '{0, 1, 1, 0, 0, 1, 1, 1, 1, 32'h0};
    tbl[3]  = '{0, 1, 1, 0, 0, 0, 1, 0, 1, K};
    tbl[4]  = '{0, 0, 1, 0, 0, 1, 1, 0, 1, K};
    tbl[5]  = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 32'h0};
    tbl[6]  = '{0, 1, 0, 1, 1, 1, 1, 0, 0, 32'h0};
    tbl[7]  = '{0, 1, 0, 1, 1, 1, 1, 1, 0, 32'h0};
    tbl[8]  = '{0, 1, 0, 1, 1, 0, 1, 0, 0, 32'h0};
    tbl[9]  = '{0, 1, 0, 1, 1, 1, 1, 0, 0, 32'h0};
    tbl[10] = '{0, 1, 0, 1, 1, 1, 1, 1, 1, 32'h0};
    tbl[11] = '{0, 1, 0, 1, 1, 1, 0, 0, 1, K};
    tbl[12] = '{0, 1, 0, 1, 1, 1, 1, 0, 1, K};
    tbl[13] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, K};  // address moves mid-transaction
    tbl[14] = '{0, 1, 0, 1, 1, 0, 1, 0, 0, 32'h0};
    tbl[15] = '{0, 1, 0, 1, 1, 1, 1, 0, 0, 32'h0};
    tbl[16] = '{0, 1, 0, 1, 1, 1, 1, 1, 1, 32'h0};
    tbl[17] = '{0, 1, 0, 1, 1, 1, 0, 0, 1, K};
    tbl[18] = '{0, 0, 0, 0, 0, 1, 1, 0, 1, K};

    pulses = 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rst = tbl[i].rst;
      a_m0r = tbl[i].m0r; a_m0a = tbl[i].m0a;
      a_m1r = tbl[i].m1r; a_m1a = tbl[i].m1a;
      #1;
      chk($sformatf("tbl[%0d] m0_waitrequest", i), 32'(a_m0w), 32'(tbl[i].ew0));
      chk($sformatf("tbl[%0d] m1_waitrequest", i), 32'(a_m1w), 32'(tbl[i].ew1));
      chk($sformatf("tbl[%0d] s_read", i), 32'(a_sr), 32'(tbl[i].esr));
      chk($sformatf("tbl[%0d] s_address", i), 32'(a_sa), 32'(tbl[i].esa));
      chk($sformatf("tbl[%0d] m0_readdata", i), a_m0d, tbl[i].ed);
      chk($sformatf("tbl[%0d] m1_readdata", i), a_m1d, tbl[i].ed);
      chk($sformatf("tbl[%0d] protocol_error", i), 32'(a_pe), 32'd0);
      if (i >= 6 && a_sr) pulses++;
    end
    chk("contention s_read pulses", 32'(pulses), 32'd4);

    // Latency 3: stale bus value must never be returned.
    rl3_read(1'b1, 1'b0, 32'h0);
    rl3_read(1'b0, 1'b1, K);

    // Abandon in WAIT.
    @(negedge clk); b_m0r = 1; b_m0a = 1'b1;
    @(negedge clk); #1; chk("abandon s_read", 32'(b_sr), 32'd1);
    @(negedge clk); b_m0r = 0; #1;
    chk("abandon pe before", 32'(b_pe), 32'd0);
    for (int n = 3; n <= 6; n++) begin
      @(negedge clk); #1;
      chk($sformatf("abandon c%0d m0_wait", n), 32'(b_m0w), 32'd1);
      chk($sformatf("abandon c%0d pe", n), 32'(b_pe), 32'd1);
    end
    rl3_read(1'b1, 1'b1, K);
    chk("pe sticky", 32'(b_pe), 32'd1);

    // Reset during ISSUE after m0 was served last; next contested grant goes to m0.
    @(negedge clk); a_m0r = 1; a_m0a = 1'b0;
    @(negedge clk);
    @(negedge clk); #1; chk("pre-reset m0_wait", 32'(a_m0w), 32'd0);
    @(negedge clk);
    @(negedge clk); #1; chk("pre-reset s_read", 32'(a_sr), 32'd1);
    rst = 1; #1;
    chk("async reset s_read", 32'(a_sr), 32'd0);
    chk("async reset m0_wait", 32'(a_m0w), 32'd1);
    chk("async reset m1_wait", 32'(a_m1w), 32'd1);
    chk("async reset pe a", 32'(a_pe), 32'd0);
    chk("async reset pe b", 32'(b_pe), 32'd0);
    chk("async reset readdata", a_m0d, 32'h0);
    @(negedge clk); rst = 0; a_m0r = 1; a_m0a = 1'b0; a_m1r = 1; a_m1a = 1'b1;
    @(negedge clk); #1;
    chk("post-reset s_read", 32'(a_sr), 32'd1);
    chk("post-reset s_address", 32'(a_sa), 32'd0);
    @(negedge clk); #1;
    chk("post-reset m0_wait", 32'(a_m0w), 32'd0);
    chk("post-reset m1_wait", 32'(a_m1w), 32'd1);
    chk("post-reset pe", 32'(a_pe), 32'd0);
    a_m0r = 0; a_m1r = 0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
